// File: rtl/tqvp_uart_pkg.sv
// rtl/tqvp_uart_pkg.sv - shared UART peripheral types and constants
package tqvp_uart_pkg;

    localparam int UART_BYTE_W  = 8;
    localparam int BUSY_TIMEOUT = 4;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } tx_state_e;

endpackage

// File: rtl/tqvp_byte_fifo.sv
// rtl/tqvp_byte_fifo.sv - circular byte buffer with count, flush and full/empty
module tqvp_byte_fifo
    import tqvp_uart_pkg::*;
#(
    parameter int DEPTH_LOG2 = 3,
    parameter int WIDTH      = UART_BYTE_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [WIDTH-1:0]      push_data,
    input  logic                  pop,
    input  logic                  flush,
    output logic [WIDTH-1:0]      rd_data,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  do_push, do_pop;

    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];

    // flush wins over both sides; full/empty use the pre-edge count
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // storage is intentionally left out of reset
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/tqvp_uart_tx_fifo.sv
// rtl/tqvp_uart_tx_fifo.sv - TX byte FIFO feeding the UART TX core launch handshake
module tqvp_uart_tx_fifo
    import tqvp_uart_pkg::*;
#(
    parameter int DEPTH_LOG2 = 3,
    parameter int LOW_WATER  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [UART_BYTE_W-1:0] wr_data,
    input  logic                   flush,
    input  logic                   ovf_clear,
    input  logic                   tx_busy,
    output logic                   tx_en,
    output logic [UART_BYTE_W-1:0] tx_data,
    output logic                   full,
    output logic                   empty,
    output logic [DEPTH_LOG2:0]    count,
    output logic                   overflow,
    output logic                   irq_low
);

    localparam int TMR_W = $clog2(BUSY_TIMEOUT);
    localparam logic [TMR_W-1:0]    TMR_LAST = TMR_W'(BUSY_TIMEOUT - 1);
    localparam logic [DEPTH_LOG2:0] LOW_CNT  = LOW_WATER[DEPTH_LOG2:0];

    tx_state_e              state_q;
    logic [TMR_W-1:0]       timer_q;
    logic                   tx_en_q;
    logic [UART_BYTE_W-1:0] tx_data_q;
    logic                   overflow_q;
    logic [UART_BYTE_W-1:0] fifo_rd_data;
    logic                   launch_pop;

    assign launch_pop = (state_q == IDLE) && !empty && !tx_busy && !flush;

    tqvp_byte_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .WIDTH      (UART_BYTE_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (wr_en),
        .push_data (wr_data),
        .pop       (launch_pop),
        .flush     (flush),
        .rd_data   (fifo_rd_data),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

    assign irq_low  = (count <= LOW_CNT);
    assign overflow = overflow_q;
    assign tx_en    = tx_en_q;
    assign tx_data  = tx_data_q;

    // a dropped push in the same cycle as ovf_clear keeps the flag set
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q <= 1'b0;
        end else if (wr_en && full) begin
            overflow_q <= 1'b1;
        end else if (ovf_clear) begin
            overflow_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            tx_en_q   <= 1'b0;
            tx_data_q <= '0;
        end else begin
            tx_en_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (launch_pop) begin
                        tx_data_q <= fifo_rd_data;
                        tx_en_q   <= 1'b1;
                        state_q   <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    timer_q <= '0;
                    state_q <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    // give up on a core that never raises busy
                    if (tx_busy) begin
                        state_q <= WAIT_DONE;
                    end else if (timer_q == TMR_LAST) begin
                        state_q <= IDLE;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (!tx_busy) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tqvp_uart_tx_fifo.sv
// tb/tb_tqvp_uart_tx_fifo.sv - directed self-checking bench for tqvp_uart_tx_fifo
module tb_tqvp_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       flush = 1'b0;
    logic       ovf_clear = 1'b0;
    logic       tx_busy = 1'b0;
    logic       tx_en;
    logic [7:0] tx_data;
    logic       full, empty, overflow, irq_low;
    logic [3:0] count;

    int n_tests = 0;
    int n_fail  = 0;

    int   busy_len   = 20;
    bit   busy_never = 1'b0;
    bit   busy_hold  = 1'b0;
    int   busy_left  = 0;
    int   cyc        = 0;
    int   double_en  = 0;
    logic prev_en    = 1'b0;
    logic [7:0] launched[$];
    int         launch_cyc[$];

    always #5 clk = ~clk;

    tqvp_uart_tx_fifo #(.DEPTH_LOG2(3), .LOW_WATER(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .flush     (flush),
        .ovf_clear (ovf_clear),
        .tx_busy   (tx_busy),
        .tx_en     (tx_en),
        .tx_data   (tx_data),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .overflow  (overflow),
        .irq_low   (irq_low)
    );

    always @(posedge clk) cyc++;

    // TX core model plus launch recorder
    always @(negedge clk) begin
        if (tx_en) begin
            launched.push_back(tx_data);
            launch_cyc.push_back(cyc);
            if (prev_en) double_en++;
            if (!busy_never) busy_left = busy_len;
        end
        prev_en = tx_en;
        if (busy_left > 0) begin
            busy_left--;
            tx_busy = 1'b1;
        end else begin
            tx_busy = busy_hold;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [7:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic wait_launches(input int n, input string tag);
        int k = 0;
        while (launched.size() < n && k < 400) begin
            tick();
            k++;
        end
        check(tag, launched.size(), n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int b;
        int exp_cnt;
        int k;

        // reset state
        tick(2);
        rst = 1'b0;
        check("rst_count", count, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_ovf", overflow, 0);
        check("rst_tx_en", tx_en, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_irq_low", irq_low, 1);

        // single byte latency
        b = launched.size();
        push(8'h55);
        check("t1_count_after_push", count, 1);
        check("t1_tx_en_early", tx_en, 0);
        tick();
        check("t1_tx_en", tx_en, 1);
        check("t1_tx_data", tx_data, 8'h55);
        check("t1_count_after_pop", count, 0);
        check("t1_empty", empty, 1);
        tick();
        check("t1_tx_en_one_cycle", tx_en, 0);
        tick(30);
        check("t1_launch_count", launched.size(), b + 1);

        // burst to full, then overflow
        b = launched.size();
        busy_hold = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) push(8'(i));
        check("t2_full", full, 1);
        check("t2_count8", count, 8);
        check("t2_irq_low", irq_low, 0);
        push(8'hAA);
        check("t2_overflow", overflow, 1);
        check("t2_count_kept", count, 8);
        busy_hold = 1'b0;
        wait_launches(b + 8, "t2_drain");
        tick(30);
        check("t2_no_extra", launched.size(), b + 8);
        for (int i = 0; i < 8; i++) begin
            if (b + i < launched.size()) check("t2_order", launched[b + i], i);
        end
        ovf_clear = 1'b1;
        tick();
        ovf_clear = 1'b0;
        check("t2_ovf_cleared", overflow, 0);

        // pointer wrap
        b = launched.size();
        busy_hold = 1'b1;
        tick();
        for (int i = 0; i < 6; i++) push(8'hE0 + 8'(i));
        busy_hold = 1'b0;
        wait_launches(b + 6, "t3_pre_drain");
        tick(30);
        b = launched.size();
        busy_hold = 1'b1;
        tick();
        for (int i = 0; i < 6; i++) begin
            push(8'h10 + 8'(i));
            check("t3_fill_count", count, i + 1);
            check("t3_fill_irq", irq_low, (i + 1) <= 2);
        end
        busy_hold = 1'b0;
        exp_cnt = 6;
        k = 0;
        while (exp_cnt > 0 && k < 400) begin
            tick();
            k++;
            if (tx_en) begin
                exp_cnt--;
                check("t3_drain_count", count, exp_cnt);
                check("t3_drain_irq", irq_low, exp_cnt <= 2);
            end
        end
        check("t3_drained", exp_cnt, 0);
        tick(30);
        for (int i = 0; i < 6; i++) begin
            if (b + i < launched.size()) check("t3_order", launched[b + i], 8'h10 + i);
        end

        // flush with a byte in flight
        b = launched.size();
        push(8'h33);
        tick(2);
        for (int i = 0; i < 4; i++) push(8'h41 + 8'(i));
        check("t4_queued", count, 4);
        flush   = 1'b1;
        wr_en   = 1'b1;
        wr_data = 8'h99;
        tick();
        flush   = 1'b0;
        wr_en   = 1'b0;
        check("t4_count_flushed", count, 0);
        check("t4_empty", empty, 1);
        tick(40);
        check("t4_only_inflight", launched.size(), b + 1);
        if (launched.size() > b) check("t4_inflight_byte", launched[b], 8'h33);
        check("t4_tx_data_kept", tx_data, 8'h33);
        push(8'h5A);
        wait_launches(b + 2, "t4_after_flush");
        if (launched.size() > b + 1) check("t4_next_byte", launched[b + 1], 8'h5A);
        tick(30);

        // core that never raises busy
        busy_never = 1'b1;
        b = launched.size();
        wr_en   = 1'b1;
        wr_data = 8'h61;
        tick();
        wr_data = 8'h62;
        tick();
        wr_en   = 1'b0;
        wait_launches(b + 2, "t5_timeout_launch");
        if (launched.size() > b + 1) begin
            check("t5_byte0", launched[b], 8'h61);
            check("t5_byte1", launched[b + 1], 8'h62);
            check("t5_gap", launch_cyc[b + 1] - launch_cyc[b], 6);
        end
        busy_hold = 1'b1;
        tick(2);
        for (int i = 0; i < 8; i++) push(8'h80 + 8'(i));
        check("t5_full", full, 1);
        wr_en     = 1'b1;
        wr_data   = 8'hBB;
        ovf_clear = 1'b1;
        tick();
        wr_en     = 1'b0;
        ovf_clear = 1'b0;
        check("t5_ovf_set_wins", overflow, 1);
        check("t5_count8", count, 8);
        busy_hold = 1'b0;
        wait_launches(b + 10, "t5_drain");
        tick(20);
        for (int i = 0; i < 8; i++) begin
            if (b + 2 + i < launched.size()) check("t5_order", launched[b + 2 + i], 8'h80 + i);
        end
        busy_never = 1'b0;

        // reset while waiting for busy to drop
        b = launched.size();
        push(8'h71);
        tick(2);
        for (int i = 0; i < 3; i++) push(8'h72 + 8'(i));
        check("t6_queued", count, 3);
        check("t6_ovf_before", overflow, 1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_count", count, 0);
        check("t6_empty", empty, 1);
        check("t6_ovf", overflow, 0);
        check("t6_tx_en", tx_en, 0);
        check("t6_tx_data", tx_data, 0);
        tick(40);
        check("t6_no_launch", launched.size(), b + 1);
        check("single_cycle_tx_en", double_en, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tqvp_uart_tx_fifo.md
Name: tqvp_uart_tx_fifo

Overview:
- Transmit byte FIFO sitting directly upstream of the UART TX core inside the UART peripheral wrapper.
- Absorbs bursts of CPU byte writes and drains them one at a time into the TX core's enable/data/busy handshake.
- Adds full/empty/count status, a sticky overflow flag and a low-water interrupt, so firmware writes in blocks instead of polling busy per byte.

Parameters:
- DEPTH_LOG2, 3, log2 of FIFO depth (default depth 8 entries of 8 bits).
- LOW_WATER, 2, irq_low asserts while count <= LOW_WATER.

Ports:
- clk  in  1  project clock (64 MHz nominal).
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  push strobe, one byte per cycle high.
- wr_data  in  8  byte to push.
- flush  in  1  discard all queued bytes.
- ovf_clear  in  1  clear sticky overflow flag.
- tx_busy  in  1  busy from UART TX core.
- tx_en  out  1  one-cycle launch strobe to UART TX core.
- tx_data  out  8  byte presented with tx_en.
- full  out  1  count == 2**DEPTH_LOG2.
- empty  out  1  count == 0.
- count  out  DEPTH_LOG2+1  bytes queued, excluding the byte in flight.
- overflow  out  1  sticky: a push was dropped.
- irq_low  out  1  count <= LOW_WATER.

Behaviour:
- Storage and pointers:
  - Circular buffer with rd_ptr/wr_ptr of DEPTH_LOG2 bits, wrapping modulo depth.
  - Separate count register of DEPTH_LOG2+1 bits.
  - full, empty and irq_low are combinational from count.
- Reset (rst=1 at a clk edge):
  - Pointers, count, overflow and tx_data are cleared to 0; tx_en is 0.
  - FSM goes to IDLE.
  - Storage contents are not reset.
  - Reset mid-transfer abandons the in-flight byte from this block's side; the TX core is reset by its own reset.
- Push:
  - wr_en && !full writes wr_data at wr_ptr; wr_ptr and count are incremented on the next edge.
  - wr_en && full drops the byte, sets overflow and leaves pointers and count unchanged.
  - full is evaluated on the pre-edge count, so a push in the same cycle as a pop when full is still dropped.
- Pop and launch FSM. States: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE.
  - IDLE: if count != 0 and !tx_busy, then:
    - tx_data <= mem[rd_ptr];
    - rd_ptr++, count-- (the pop);
    - next state is LAUNCH.
    - Otherwise stay in IDLE.
  - LAUNCH: tx_en = 1 for exactly this one cycle; next state is WAIT_BUSY.
  - WAIT_BUSY: stay until tx_busy = 1, then go to WAIT_DONE.
    - A timeout of 4 cycles returns to IDLE, so a TX core that never rises busy cannot deadlock the FIFO.
  - WAIT_DONE: stay until tx_busy = 0, then go to IDLE.
  - tx_data holds its value from the pop until the next pop.
- Timing:
  - Latency: push at edge N into an empty FIFO with TX idle gives a pop at edge N+1 and tx_en high during cycle N+1..N+2. First byte launches 2 cycles after the write.
  - Throughput: one byte per UART frame plus 3 cycles of FSM overhead (LAUNCH, WAIT_BUSY edge, IDLE).
- Simultaneous events:
  - Push and pop in the same cycle: count is unchanged and both pointers advance.
  - flush has priority over push and pop. rd_ptr <= wr_ptr and count <= 0; a push or pop in that cycle is ignored.
  - flush does not abort the in-flight byte: FSM states LAUNCH/WAIT_* continue and tx_data is kept.
  - ovf_clear and a dropped push in the same cycle: set wins, overflow stays 1.
- Width rules:
  - count reaches exactly 2**DEPTH_LOG2 at full and never exceeds it.
  - Pointer wrap from depth-1 to 0 is by natural truncation.

Decomposition:
- Shared package tqvp_uart_pkg:
  - FSM state typedef (IDLE/LAUNCH/WAIT_BUSY/WAIT_DONE, 2-bit encoding 0..3).
  - BUSY_TIMEOUT constant = 4.
  - UART byte width constant = 8.
- One natural sub-module: tqvp_byte_fifo (storage, pointers, count, flush, full/empty). The launch FSM stays in the top. The same FIFO is reused later for an RX buffer.

Test Plan:
- Reset then single write 0x55, TX model raising busy 1 cycle after tx_en for 20 cycles:
  - tx_en high exactly 1 cycle, 2 cycles after the write, with tx_data=0x55.
  - count goes 1->0; empty=1 afterwards.
- Burst of 8 writes 0x00..0x07 back-to-back with TX model busy:
  - full=1 after the 8th write; a 9th write of 0xAA sets overflow=1 and leaves count=8.
  - Bytes are launched in order 0x00..0x07; 0xAA never appears.
- Pointer wrap: 6 writes, drain 6, then 6 more (0x10..0x15):
  - Output order is 0x10..0x15, count correct throughout, irq_low toggles at count 3->2.
- Flush with byte 0x33 in flight and 4 queued:
  - 0x33 still completes; no further tx_en; count=0 the cycle after flush.
  - A write in the flush cycle is dropped.
- TX model that never raises busy:
  - FSM returns to IDLE after 4 cycles in WAIT_BUSY; the next queued byte launches.
  - ovf_clear asserted the same cycle as an overflowing push leaves overflow=1.
- rst asserted while in WAIT_DONE with 3 queued:
  - Next cycle count=0, empty=1, overflow=0, tx_en=0; no launch until a new write.
